regfile_wport_arb: RTL and testbench
====================================

# regfile_wport_arb

Arbiter and scoreboard for the single register-file write port. Shares the port between the in-order writeback stage, which always has priority, and the multi-cycle unit (mul/div) via a small result queue. Tracks destinations of in-flight multi-cycle ops so decode can stall on RAW/WAW hazards. Sits between stage_wb, the multi-cycle unit and the `regs` array; it replaces the direct write in writeback.

## Interface
Parameters:
- `XLEN`, 32, data width
- `QDEPTH`, 2, multi-cycle result queue depth (≥1)
- `STARVE_MAX`, 4, consecutive blocked cycles before `wb_hold` is raised

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: reset, synchronous, active-low
- `wb_valid` in 1: writeback wants to write (`WB.w_rd`)
- `wb_rd` in 5: writeback destination
- `wb_data` in XLEN: writeback data
- `lu_valid` in 1: multi-cycle result available
- `lu_rd` in 5: multi-cycle result destination
- `lu_data` in XLEN: multi-cycle result data
- `lu_ready` out 1: queue can accept a result
- `iss_valid` in 1: multi-cycle op issued this cycle
- `iss_rd` in 5: its destination
- `q_rs1`, `q_rs2`, `q_rd` in 5 each: decode operands to check
- `hazard` out 1: any queried register is busy
- `wb_hold` out 1: request a one-cycle pipeline freeze so the queue can drain
- `rf_we` out 1: register-file write enable
- `rf_waddr` out 5: write address
- `rf_wdata` out XLEN: write data

## Operation
- **Write-port mux** (combinational):
  - If `wb_valid` and `wb_rd`≠0: write from writeback.
  - Else if the queue is not empty: write the queue head and pop it.
  - Else: `rf_we`=0.
- Writes to r0 are dropped: `rf_we`=0, and no busy bit changes.
- **Queue:** FIFO of {rd, data}, QDEPTH entries.
  - `lu_ready` = !full.
  - Push on `lu_valid && lu_ready`.
  - `lu_valid` with `lu_ready`=0 is held by the producer.
  - Push and pop in the same cycle is allowed when full: the pop frees the slot for the next cycle only. `lu_ready` stays 0 that cycle.
  - Entries with rd=0 are popped without a write.
- **Scoreboard:** busy[31:1].
  - Set on `iss_valid` with `iss_rd`≠0.
  - Cleared when that register is written from the queue.
  - Set and clear on the same register in the same cycle: set wins.
  - `iss_valid` to an already-busy register is illegal; the bench asserts this never happens.
  - `hazard` = busy[q_rs1] | busy[q_rs2] | busy[q_rd]. busy[0] reads 0.
- **Starvation counter:**
  - Increments each cycle the queue is non-empty and loses to writeback.
  - Resets on any pop or when the queue is empty.
  - When the count reaches STARVE_MAX, `wb_hold`=1 for exactly one cycle. The pipeline then presents `wb_valid`=0, the queue drains one entry, and the counter returns to 0.
- **Reset:** while `rst_n`=0 at an edge, clear queue, busy, counter and hold.
  - Outputs after reset: `rf_we`=0, `hazard`=0, `wb_hold`=0, `lu_ready`=1.
  - Writes are gated off while `rst_n` is low.
  - Reset mid-operation discards queued results with no write.

## Timing
- The write-port outputs are combinational from the current inputs and the queue head; the register file captures on the next `clk` edge, as writeback does today.
- Pushed results are poppable from the cycle after the push. There is no same-cycle bypass through an empty queue.
- `hazard` reflects busy state registered at the last edge. An op issued at edge N is visible as `hazard` from cycle N+1. A register written from the queue at edge N stops being busy in cycle N+1.
- `wb_hold` is a registered output.
- Latency from `lu_valid` to register-file write: minimum 1 cycle, maximum (QDEPTH)·(STARVE_MAX+1) cycles.

## Structure
- Shared package `br32_pkg`: `REG_AW`=5; `rf_wr_t` {we, addr[4:0], data[XLEN-1:0]}; `lu_res_t` {rd, data}.
- Sub-module `sync_fifo` (parameterized width/depth, push/pop/full/empty) holds the queue.
- Scoreboard, arbitration mux and starvation counter stay in the top module.

## Test plan
- **Idle priority:** `lu_valid` rd=5 data=0xAA with writeback idle → write r5=0xAA one cycle later, then `lu_ready` stays 1 and busy[5] clears.
- **Conflict:** same cycle `wb_valid` rd=3 data=0x11 and queue head rd=7 → r3=0x11 written; r7 written the next cycle when `wb_valid`=0.
- **Starvation:** queue holds rd=9, `wb_valid`=1 (rd≠0) every cycle → `wb_hold` pulses after 4 blocked cycles; r9 written in the freeze cycle; the counter returns to 0.
- **Backpressure:** QDEPTH=2 filled with rd=1, rd=2 while writeback is busy → `lu_ready`=0, and the third result is held until a pop occurs.
- **Hazard:** issue rd=12 → `hazard`=1 for `q_rs2`=12 from the next cycle until r12 is written from the queue; a writeback write to rd=0 produces `rf_we`=0.
- **Reset mid-op:** two queued entries, `rst_n`=0 for one edge → no writes, all busy cleared, `lu_ready`=1.

Source files
------------

// File: rtl/br32_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package br32_pkg;

  localparam int REG_AW  = 5;
  localparam int BR_XLEN = 32;

  // One register-file write request.
  typedef struct packed {
    logic                 we;
    logic [REG_AW-1:0]    addr;
    logic [BR_XLEN-1:0]   data;
  } rf_wr_t;

  // One multi-cycle unit result.
  typedef struct packed {
    logic [REG_AW-1:0]    rd;
    logic [BR_XLEN-1:0]   data;
  } lu_res_t;

  // One-hot mask selecting a single architectural register.
  function automatic logic [31:0] reg_onehot(input logic [REG_AW-1:0] r);
    return 32'h0000_0001 << r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and full/empty flags.
// Pushes while full and pops while empty are ignored; a pop while full
// frees a slot only for the following cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign full      = (cnt_r == CNT_FULL);
  assign empty     = (cnt_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: writeback has priority, multi-cycle
// results wait in a small queue, a scoreboard tracks in-flight destinations,
// and a starvation counter requests a one-cycle freeze so the queue drains.
module regfile_wport_arb
  import br32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_rd,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] q_rs1,
  input  logic [REG_AW-1:0] q_rs2,
  input  logic [REG_AW-1:0] q_rd,
  output logic              hazard,
  output logic              wb_hold,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam int CNTW = $clog2(STARVE_MAX + 1);
  localparam logic [CNTW-1:0]   STARVE_LIM = CNTW'(STARVE_MAX);
  localparam logic [REG_AW-1:0] R_ZERO     = {REG_AW{1'b0}};

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } res_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_t;

  res_t            q_in_s;
  res_t            q_head_s;
  logic            q_full_s;
  logic            q_empty_s;
  logic            push_s;
  logic            pop_s;
  logic            wb_wr_s;
  wr_t             wr_s;
  logic [31:0]     busy_r;
  logic [31:0]     busy_nxt_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [CNTW-1:0] starve_r;
  logic [CNTW-1:0] starve_nxt_s;
  logic            wb_hold_r;
  logic            hold_nxt_s;

  assign q_in_s   = '{rd: lu_rd, data: lu_data};
  assign wb_wr_s  = wb_valid && (wb_rd != R_ZERO);
  assign push_s   = lu_valid && !q_full_s;
  // The queue only gets the port when writeback leaves it idle.
  assign pop_s    = rst_n && !wb_wr_s && !q_empty_s;
  assign lu_ready = !q_full_s;

  sync_fifo #(
    .WIDTH (REG_AW + XLEN),
    .DEPTH (QDEPTH)
  ) u_res_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (q_in_s),
    .dout  (q_head_s),
    .full  (q_full_s),
    .empty (q_empty_s)
  );

  // Write-port mux: writeback first, then the queue head; r0 never written.
  always_comb begin
    wr_s = '{we: 1'b0, addr: R_ZERO, data: {XLEN{1'b0}}};
    if (!rst_n) begin
      wr_s.we = 1'b0;
    end else if (wb_wr_s) begin
      wr_s.we   = 1'b1;
      wr_s.addr = wb_rd;
      wr_s.data = wb_data;
    end else if (pop_s && (q_head_s.rd != R_ZERO)) begin
      wr_s.we   = 1'b1;
      wr_s.addr = q_head_s.rd;
      wr_s.data = q_head_s.data;
    end else begin
      wr_s.we = 1'b0;
    end
  end

  assign rf_we    = wr_s.we;
  assign rf_waddr = wr_s.addr;
  assign rf_wdata = wr_s.data;

  // Scoreboard next state: clear on queue write, set on issue (set wins), r0 forced idle.
  assign set_mask_s = (iss_valid && rst_n) ? reg_onehot(iss_rd) : 32'h0000_0000;
  assign clr_mask_s = pop_s ? reg_onehot(q_head_s.rd) : 32'h0000_0000;
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

  assign hazard  = busy_r[q_rs1] | busy_r[q_rs2] | busy_r[q_rd];
  assign wb_hold = wb_hold_r;

  // Starvation count: grows while the queue loses to writeback, pulses hold on arrival at the limit.
  always_comb begin
    starve_nxt_s = starve_r;
    hold_nxt_s   = 1'b0;
    if (q_empty_s || pop_s) begin
      starve_nxt_s = {CNTW{1'b0}};
    end else if (wb_wr_s && (starve_r != STARVE_LIM)) begin
      starve_nxt_s = starve_r + CNTW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
    if ((starve_nxt_s == STARVE_LIM) && (starve_r != STARVE_LIM)) begin
      hold_nxt_s = 1'b1;
    end else begin
      hold_nxt_s = 1'b0;
    end
  end

  // Scoreboard, starvation counter and hold register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r    <= 32'h0000_0000;
      starve_r  <= {CNTW{1'b0}};
      wb_hold_r <= 1'b0;
    end else begin
      busy_r    <= busy_nxt_s;
      starve_r  <= starve_nxt_s;
      wb_hold_r <= hold_nxt_s;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed bench for regfile_wport_arb: a cycle-by-cycle vector table plus
// hand-written reset and starvation sequences.
module tb_regfile_wport_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        hazard;
  logic        wb_hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        rst_n;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        luv;
    logic [4:0]  lurd;
    logic [31:0] lud;
    logic        issv;
    logic [4:0]  issrd;
    logic [4:0]  rs1, rs2, rd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        hz;
    logic        hold;
  } vec_t;

  vec_t vecs[$];

  regfile_wport_arb #(.XLEN(32), .QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .lu_valid  (lu_valid),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .lu_ready  (lu_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_rd      (q_rd),
    .hazard    (hazard),
    .wb_hold   (wb_hold),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic row(input int rst, input int wbv, input int wbrd, input int wbd,
                     input int luv, input int lurd, input int lud,
                     input int issv, input int issrd,
                     input int rs1, input int rs2, input int rd,
                     input int we, input int wa, input int wd,
                     input int rdy, input int hz, input int hold);
    vec_t v;
    v.rst_n = 1'(rst);  v.wbv  = 1'(wbv);  v.wbrd = 5'(wbrd); v.wbd = 32'(wbd);
    v.luv   = 1'(luv);  v.lurd = 5'(lurd); v.lud  = 32'(lud);
    v.issv  = 1'(issv); v.issrd = 5'(issrd);
    v.rs1   = 5'(rs1);  v.rs2  = 5'(rs2);  v.rd   = 5'(rd);
    v.we    = 1'(we);   v.wa   = 5'(wa);   v.wd   = 32'(wd);
    v.rdy   = 1'(rdy);  v.hz   = 1'(hz);   v.hold = 1'(hold);
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'h0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    q_rs1 = 5'd0; q_rs2 = 5'd0; q_rd = 5'd0;
  endtask

  initial begin
    int hold_cyc;

    // row(rst, wbv,wbrd,wbd, luv,lurd,lud, issv,issrd, rs1,rs2,rd, we,wa,wd, rdy,hz,hold)
    // Idle priority: issue r5, result arrives, written next cycle, busy clears.
    row(1, 0,0,0,      0,0,0,          1,5,  5,0,0,   0,0,0,           1,0,0);
    row(1, 0,0,0,      1,5,'hAA,       0,0,  5,0,0,   0,0,0,           1,1,0);
    row(1, 0,0,0,      0,0,0,          0,0,  5,0,0,   1,5,'hAA,        1,1,0);
    row(1, 0,0,0,      0,0,0,          0,0,  5,0,0,   0,0,0,           1,0,0);
    // Conflict: writeback r3 beats queued r7, r7 follows.
    row(1, 0,0,0,      1,7,'h77,       1,7,  0,0,0,   0,0,0,           1,0,0);
    row(1, 1,3,'h11,   0,0,0,          0,0,  0,0,7,   1,3,'h11,        1,1,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,0,7,   1,7,'h77,        1,1,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,0,7,   0,0,0,           1,0,0);
    // Hazard on q_rs2=12; writeback to r0 is dropped and lets the queue through.
    row(1, 0,0,0,      0,0,0,          1,12, 0,12,0,  0,0,0,           1,0,0);
    row(1, 1,0,'hDEAD, 0,0,0,          0,0,  0,12,0,  0,0,0,           1,1,0);
    row(1, 1,6,'h66,   1,12,'hC0FFEE,  0,0,  0,12,0,  1,6,'h66,        1,1,0);
    row(1, 1,0,'h5,    0,0,0,          0,0,  0,12,0,  1,12,'hC0FFEE,   1,1,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,12,0,  0,0,0,           1,0,0);
    // Backpressure: fill with r1, r2 while writeback busy; r3 held until a pop.
    row(1, 1,4,'h44,   1,1,'h101,      0,0,  0,0,0,   1,4,'h44,        1,0,0);
    row(1, 1,4,'h45,   1,2,'h102,      0,0,  0,0,0,   1,4,'h45,        1,0,0);
    row(1, 1,4,'h46,   1,3,'h103,      0,0,  0,0,0,   1,4,'h46,        0,0,0);
    row(1, 1,4,'h47,   1,3,'h103,      0,0,  0,0,0,   1,4,'h47,        0,0,0);
    row(1, 0,0,0,      1,3,'h103,      0,0,  0,0,0,   1,1,'h101,       0,0,0);
    row(1, 0,0,0,      1,3,'h103,      0,0,  0,0,0,   1,2,'h102,       1,0,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,0,0,   1,3,'h103,       1,0,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,0,0,   0,0,0,           1,0,0);
    // Starvation: r9 blocked four cycles, hold in the freeze cycle, r9 written.
    row(1, 1,4,'h1,    1,9,'h99,       1,9,  0,0,0,   1,4,'h1,         1,0,0);
    row(1, 1,4,'h2,    0,0,0,          0,0,  9,0,0,   1,4,'h2,         1,1,0);
    row(1, 1,4,'h3,    0,0,0,          0,0,  9,0,0,   1,4,'h3,         1,1,0);
    row(1, 1,4,'h4,    0,0,0,          0,0,  9,0,0,   1,4,'h4,         1,1,0);
    row(1, 1,4,'h5,    0,0,0,          0,0,  9,0,0,   1,4,'h5,         1,1,0);
    row(1, 0,0,0,      0,0,0,          0,0,  9,0,0,   1,9,'h99,        1,1,1);
    row(1, 1,4,'h7,    0,0,0,          0,0,  9,0,0,   1,4,'h7,         1,0,0);
    // A queued rd=0 result pops without a write.
    row(1, 0,0,0,      1,0,'hBAD,      0,0,  0,0,0,   0,0,0,           1,0,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,0,0,   0,0,0,           1,0,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,0,0,   0,0,0,           1,0,0);
    // Reset mid-operation with two queued entries: nothing written, busy cleared.
    row(1, 1,4,'h0,    1,13,'hD13,     1,13, 0,0,0,   1,4,'h0,         1,0,0);
    row(1, 1,4,'h0,    1,14,'hD14,     1,14, 13,0,0,  1,4,'h0,         1,1,0);
    row(0, 1,4,'h0,    0,0,0,          0,0,  13,14,0, 0,0,0,           0,1,0);
    row(1, 0,0,0,      0,0,0,          0,0,  13,14,0, 0,0,0,           1,0,0);
    row(1, 0,0,0,      0,0,0,          0,0,  0,0,0,   0,0,0,           1,0,0);

    // Reset with activity on every input: writes gated, nothing recorded.
    idle_inputs();
    rst_n = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'h55;
    iss_valid = 1'b1; iss_rd = 5'd6; q_rs1 = 5'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we",     32'(rf_we),    32'd0);
    check("rst_hazard", 32'(hazard),   32'd0);
    check("rst_hold",   32'(wb_hold),  32'd0);
    check("rst_ready",  32'(lu_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst_n;
      wb_valid = vecs[i].wbv;  wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
      lu_valid = vecs[i].luv;  lu_rd = vecs[i].lurd; lu_data = vecs[i].lud;
      iss_valid = vecs[i].issv; iss_rd = vecs[i].issrd;
      q_rs1 = vecs[i].rs1; q_rs2 = vecs[i].rs2; q_rd = vecs[i].rd;
      @(negedge clk);
      check($sformatf("r%0d_we", i), 32'(rf_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("r%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].wa));
        check($sformatf("r%0d_wdata", i), rf_wdata, vecs[i].wd);
      end
      check($sformatf("r%0d_ready", i),  32'(lu_ready), 32'(vecs[i].rdy));
      check($sformatf("r%0d_hazard", i), 32'(hazard),   32'(vecs[i].hz));
      check($sformatf("r%0d_hold", i),   32'(wb_hold),  32'(vecs[i].hold));
    end

    // Second starvation episode: the pipeline reacts to wb_hold itself,
    // proving the counter restarted from zero after the first freeze.
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA0;
    @(negedge clk);
    check("st_push_wb", 32'(rf_waddr), 32'd4);
    hold_cyc = -1;
    for (int i = 1; i <= 12 && hold_cyc < 0; i++) begin
      @(posedge clk);
      #1;
      lu_valid = 1'b0;
      if (wb_hold) begin
        wb_valid = 1'b0;
        hold_cyc = i;
      end else begin
        wb_valid = 1'b1;
      end
      @(negedge clk);
      if (hold_cyc == i) begin
        check("st_freeze_we",    32'(rf_we),    32'd1);
        check("st_freeze_waddr", 32'(rf_waddr), 32'd10);
        check("st_freeze_wdata", rf_wdata,      32'hA0);
      end
    end
    check("st_hold_cycle", 32'(hold_cyc), 32'd5);
    @(posedge clk);
    #1;
    wb_valid = 1'b1;
    @(negedge clk);
    check("st_hold_drop", 32'(wb_hold), 32'd0);
    check("st_wb_after",  32'(rf_waddr), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
